// File: rtl/shared_unit_pkg.sv
// Shared types and helpers for the shared-unit arbiter.
// State encoding and a constant-friendly clog2.
package shared_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_unit_arbiter_rr_pick.sv
// Rotating-priority selector: first set request after last,
// scanning upward with wrap.
module rr_pick import shared_unit_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(last) + i) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin sharing of one multi-cycle unit between requesters.
// Outputs are registered from next-cycle values.
module shared_unit_arbiter import shared_unit_pkg::*; #(
    parameter int N_REQ    = 4,
    parameter int W        = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_operand,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [W-1:0]             rsp_data,
    output logic                     rsp_error,
    output logic                     unit_start,
    output logic [W-1:0]             unit_operand,
    input  logic                     unit_done,
    input  logic [W-1:0]             unit_result,
    output logic [clog2(N_REQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic              wait_end;

    logic [N_REQ-1:0]  req_ready_d, rsp_valid_d;
    logic [W-1:0]      rsp_data_d, operand_d;
    logic              rsp_error_d, unit_start_d, busy_d;
    logic [IW-1:0]     grant_d;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Limit cycle is the last WAIT cycle; a done there still wins.
    assign wait_end = (state_q == WAIT) &&
                      (unit_done || cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_end) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        unit_start_d = 1'b0;
        rsp_data_d   = rsp_data;
        rsp_error_d  = rsp_error;
        operand_d    = unit_operand;
        grant_d      = grant_id;
        last_d       = last_q;
        cnt_d        = cnt_q;
        busy_d       = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ready_d  = N_REQ'(1) << pick_idx;
                    unit_start_d = 1'b1;
                    grant_d      = pick_idx;
                    operand_d    = req_operand[int'(pick_idx)*W +: W];
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_q + 1'b1;
                if (wait_end) begin
                    rsp_valid_d = N_REQ'(1) << grant_id;
                    rsp_data_d  = unit_done ? unit_result : '0;
                    rsp_error_d = !unit_done;
                end
            end
            RESPOND: begin
                last_d = grant_id;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            unit_start   <= 1'b0;
            unit_operand <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            last_q       <= IW'(N_REQ - 1);
            cnt_q        <= '0;
        end else begin
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            rsp_error    <= rsp_error_d;
            unit_start   <= unit_start_d;
            unit_operand <= operand_d;
            grant_id     <= grant_d;
            busy         <= busy_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter with a stub compute unit.
// Table of transactions plus reset and spurious-done sequences.
module tb_shared_unit_arbiter;

    localparam int N_REQ    = 4;
    localparam int W        = 4;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_operand;
    logic [3:0]  req_ready, rsp_valid;
    logic [3:0]  rsp_data;
    logic        rsp_error, unit_start;
    logic [3:0]  unit_operand;
    logic        unit_done;
    logic [3:0]  unit_result;
    logic [1:0]  grant_id;
    logic        busy;

    logic        stub_done = 1'b0;
    logic        man_done  = 1'b0;
    logic [3:0]  stub_res  = '0;
    logic [3:0]  man_res   = '0;
    int          stub_k    = -1;

    int errors = 0;
    int checks = 0;

    assign unit_done   = stub_done | man_done;
    assign unit_result = stub_done ? stub_res : man_res;

    always #5 clk = ~clk;

    shared_unit_arbiter #(
        .N_REQ(N_REQ), .W(W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_operand  (req_operand),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .unit_start   (unit_start),
        .unit_operand (unit_operand),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // Stub unit: done is high during WAIT cycle stub_k (never if < 0).
    always begin
        @(negedge clk);
        if (unit_start && stub_k >= 0) begin
            repeat (stub_k + 1) @(negedge clk);
            stub_done = 1'b1;
            @(negedge clk);
            stub_done = 1'b0;
        end
    end

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] ops;
        int          k;
        logic [3:0]  res;
        bit          spur;
        int          eg;
        logic [3:0]  ed;
        logic        ee;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the IDLE
    // cycle after RESPOND.
    task automatic run_txn(input string nm, input logic [3:0] rv,
                           input logic [15:0] ops, input int k,
                           input logic [3:0] res, input bit spur,
                           input int eg, input logic [3:0] ed,
                           input logic ee);
        int  n;
        bit  bad;
        int  exp_n;
        req_valid   = rv;
        req_operand = ops;
        stub_k      = k;
        stub_res    = res;
        @(negedge clk);
        check({nm, " ready"}, 32'(req_ready), 32'(4'b1 << eg));
        check({nm, " start"}, 32'(unit_start), 32'd1);
        check({nm, " operand"}, 32'(unit_operand), 32'(ops[eg*4 +: 4]));
        check({nm, " grant_id"}, 32'(grant_id), 32'(eg));
        req_valid = '0;
        if (spur) begin
            man_done = 1'b1;
            man_res  = 4'h6;
        end
        n   = 0;
        bad = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) man_done = 1'b0;
            if (rsp_valid != 0) begin
                n = c;
                break;
            end
            if (req_ready != 0 || unit_start || !busy) bad = 1'b1;
        end
        exp_n = (k >= 0) ? 2 + k : MAX_WAIT + 1;
        check({nm, " pulses"}, 32'(bad), 32'd0);
        check({nm, " latency"}, 32'(n), 32'(exp_n));
        check({nm, " rsp_valid"}, 32'(rsp_valid), 32'(4'b1 << eg));
        check({nm, " rsp_data"}, 32'(rsp_data), 32'(ed));
        check({nm, " rsp_error"}, 32'(rsp_error), 32'(ee));
        @(negedge clk);
        check({nm, " idle"}, 32'({busy, rsp_valid, req_ready}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 16'h0005, 3,  4'hA, 1'b0, 0, 4'hA, 1'b0};
        tbl[1] = '{4'b1111, 16'hDCBA, 1,  4'h1, 1'b0, 1, 4'h1, 1'b0};
        tbl[2] = '{4'b1111, 16'hDCBA, 1,  4'h2, 1'b0, 2, 4'h2, 1'b0};
        tbl[3] = '{4'b1111, 16'hDCBA, 1,  4'h3, 1'b0, 3, 4'h3, 1'b0};
        tbl[4] = '{4'b1111, 16'hDCBA, 1,  4'h4, 1'b0, 0, 4'h4, 1'b0};
        tbl[5] = '{4'b0100, 16'h0700, 0,  4'h7, 1'b0, 2, 4'h7, 1'b0};
        tbl[6] = '{4'b0011, 16'h0021, 14, 4'h9, 1'b0, 0, 4'h9, 1'b0};
        tbl[7] = '{4'b1000, 16'hE000, -1, 4'h0, 1'b1, 3, 4'h0, 1'b1};
        tbl[8] = '{4'b0001, 16'h000F, 2,  4'h0, 1'b0, 0, 4'h0, 1'b0};

        reset       = 1'b1;
        req_valid   = '0;
        req_operand = '0;
        repeat (2) @(negedge clk);
        check("reset outputs",
              32'({req_ready, rsp_valid, rsp_data, rsp_error, unit_start,
                   unit_operand, grant_id, busy}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].rv, tbl[i].ops,
                    tbl[i].k, tbl[i].res, tbl[i].spur, tbl[i].eg,
                    tbl[i].ed, tbl[i].ee);
        end

        // Done pulse while idle must not start anything.
        man_done = 1'b1;
        man_res  = 4'h5;
        @(negedge clk);
        man_done = 1'b0;
        check("idle done", 32'({busy, rsp_valid}), 32'd0);
        @(negedge clk);
        check("idle done later", 32'({busy, rsp_valid}), 32'd0);

        // After reset, priority restarts at requester 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn("rst a", 4'b1010, 16'h3040, 0, 4'hC, 1'b0, 1, 4'hC, 1'b0);
        run_txn("rst b", 4'b1010, 16'h3040, 1, 4'hD, 1'b0, 3, 4'hD, 1'b0);

        // Reset in the middle of WAIT.
        req_valid   = 4'b0100;
        req_operand = 16'h0B00;
        stub_k      = -1;
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        check("mid wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async reset outputs",
              32'({req_ready, rsp_valid, rsp_data, rsp_error, unit_start,
                   unit_operand, grant_id, busy}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post reset quiet", 32'({busy, rsp_valid}), 32'd0);
        run_txn("rst c", 4'b0110, 16'h0870, 0, 4'h2, 1'b0, 1, 4'h2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
